branch_cond_unit: RTL



---
 rtl/branch_pkg.sv | 32 +++
 rtl/branch_cond_unit_if.sv | 23 ++
 rtl/cmp_flags.sv | 25 ++
 rtl/branch_cond_unit.sv | 132 +++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch condition path: condition codes,
// flag bit positions and the query-handshake state encoding.
package branch_pkg;

  localparam int COND_W = 4;
  localparam int FLAGS_W = 4;

  // Condition codes carried on br_cond; 10..15 are reserved.
  localparam logic [COND_W-1:0] COND_EQ  = 4'd0;
  localparam logic [COND_W-1:0] COND_NE  = 4'd1;
  localparam logic [COND_W-1:0] COND_LT  = 4'd2;
  localparam logic [COND_W-1:0] COND_GE  = 4'd3;
  localparam logic [COND_W-1:0] COND_GT  = 4'd4;
  localparam logic [COND_W-1:0] COND_LE  = 4'd5;
  localparam logic [COND_W-1:0] COND_LTU = 4'd6;
  localparam logic [COND_W-1:0] COND_GEU = 4'd7;
  localparam logic [COND_W-1:0] COND_AL  = 4'd8;
  localparam logic [COND_W-1:0] COND_NV  = 4'd9;

  // Bit positions inside the {Z,N,C,V} flags word.
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Query handshake states.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } br_state_e;

endpackage

// File: rtl/branch_cond_unit_if.sv
// Branch query handshake between the sequencer (master) and the
// branch condition unit (slave).
interface branch_cond_unit_if;
  import branch_pkg::*;

  logic              br_valid;
  logic [COND_W-1:0] br_cond;
  logic              br_ready;
  logic              br_done;
  logic              br_taken;
  logic              br_illegal;

  modport master (
    output br_valid, br_cond,
    input  br_ready, br_done, br_taken, br_illegal
  );

  modport slave (
    input  br_valid, br_cond,
    output br_ready, br_done, br_taken, br_illegal
  );

endinterface

// File: rtl/cmp_flags.sv
// Combinational flag generator for a subtraction op1 - op2 whose
// difference is supplied externally. Produces {Z,N,C,V}, where C is
// the borrow (op1 < op2 unsigned).
module cmp_flags
  import branch_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]   op1,
  input  logic [WIDTH-1:0]   op2,
  input  logic [WIDTH-1:0]   diff,
  output logic [FLAGS_W-1:0] flags
);

  // Derive each flag from the operands and the difference.
  always_comb begin
    flags         = 4'b0000;
    flags[FLAG_Z] = (diff == {WIDTH{1'b0}});
    flags[FLAG_N] = diff[WIDTH-1];
    flags[FLAG_C] = (op1 < op2);
    flags[FLAG_V] = (op1[WIDTH-1] != op2[WIDTH-1]) &&
                    (diff[WIDTH-1] != op1[WIDTH-1]);
  end

endmodule

// File: rtl/branch_cond_unit.sv
// Branch condition unit: captures compare operands, folds them with the
// compare unit's registered difference into a flags register one cycle
// later, and resolves conditional-branch queries over a valid/ready
// handshake. Queries stall while a flag update is outstanding.
module branch_cond_unit
  import branch_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmp_start,
  input  logic [WIDTH-1:0]    op1,
  input  logic [WIDTH-1:0]    op2,
  input  logic [WIDTH-1:0]    cmp_result,
  branch_cond_unit_if.slave   br,
  output logic [FLAGS_W-1:0]  flags
);

  logic [WIDTH-1:0]   op1_r;
  logic [WIDTH-1:0]   op2_r;
  logic               pending_r;
  logic [FLAGS_W-1:0] flags_r;
  logic [FLAGS_W-1:0] new_flags_s;
  br_state_e          state_r;
  br_state_e          state_nxt_s;
  logic               taken_r;
  logic               illegal_r;
  logic               ready_s;
  logic               accept_s;
  logic               cond_taken_s;
  logic               cond_illegal_s;
  logic               n_xor_v_s;

  cmp_flags #(.WIDTH(WIDTH)) u_cmp_flags (
    .op1   (op1_r),
    .op2   (op2_r),
    .diff  (cmp_result),
    .flags (new_flags_s)
  );

  // Capture stage: hold the operands of the compare issued this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op1_r     <= {WIDTH{1'b0}};
      op2_r     <= {WIDTH{1'b0}};
      pending_r <= 1'b0;
    end else begin
      pending_r <= cmp_start;
      if (cmp_start) begin
        op1_r <= op1;
        op2_r <= op2;
      end
    end
  end

  // Flags register updates the cycle after a compare was issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_r <= 4'b0000;
    end else if (pending_r) begin
      flags_r <= new_flags_s;
    end
  end

  // Evaluate the queried condition against the current flags.
  always_comb begin
    cond_taken_s   = 1'b0;
    cond_illegal_s = 1'b0;
    n_xor_v_s      = flags_r[FLAG_N] ^ flags_r[FLAG_V];
    case (br.br_cond)
      COND_EQ:  cond_taken_s = flags_r[FLAG_Z];
      COND_NE:  cond_taken_s = !flags_r[FLAG_Z];
      COND_LT:  cond_taken_s = n_xor_v_s;
      COND_GE:  cond_taken_s = !n_xor_v_s;
      COND_GT:  cond_taken_s = !flags_r[FLAG_Z] && !n_xor_v_s;
      COND_LE:  cond_taken_s = flags_r[FLAG_Z] || n_xor_v_s;
      COND_LTU: cond_taken_s = flags_r[FLAG_C];
      COND_GEU: cond_taken_s = !flags_r[FLAG_C];
      COND_AL:  cond_taken_s = 1'b1;
      COND_NV:  cond_taken_s = 1'b0;
      default:  cond_illegal_s = 1'b1;
    endcase
  end

  // Ready depends only on registered state, never on br_valid/cmp_start.
  assign ready_s  = (state_r == ST_IDLE) && !pending_r;
  assign accept_s = br.br_valid && ready_s;

  // Handshake next-state logic.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Handshake state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Latch the result on accept; it persists until the next accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      taken_r   <= 1'b0;
      illegal_r <= 1'b0;
    end else if (accept_s) begin
      taken_r   <= cond_taken_s;
      illegal_r <= cond_illegal_s;
    end
  end

  assign br.br_ready   = ready_s;
  assign br.br_done    = (state_r == ST_RESP);
  assign br.br_taken   = taken_r;
  assign br.br_illegal = illegal_r;
  assign flags         = flags_r;

endmodule
